spio_hss_multiplexer_reg_access: RTL and testbench

//  Register access sequencer in front of the HSS multiplexer register bank.

---
 rtl/spio_hss_multiplexer_reg_access.sv | 111 +++++++++++
 tb/tb_spio_hss_multiplexer_reg_access.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/spio_hss_multiplexer_reg_access.sv
// Register access sequencer for the HSS multiplexer register bank: one request in flight,
// drives the bank strobes, waits out its registered read latency and returns one response word.
module spio_hss_multiplexer_reg_access #(
    parameter int unsigned REGA_BITS = 5,
    parameter int unsigned REGD_BITS = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_vld_i,
    output logic                 req_rdy_o,
    input  logic                 req_wr_i,
    input  logic [REGA_BITS-1:0] req_addr_i,
    input  logic [REGD_BITS-1:0] req_wdata_i,
    output logic                 rsp_vld_o,
    input  logic                 rsp_rdy_i,
    output logic [REGD_BITS-1:0] rsp_data_o,
    output logic                 rsp_wr_o,
    output logic                 reg_write_o,
    output logic [REGA_BITS-1:0] reg_addr_o,
    output logic [REGD_BITS-1:0] reg_write_data_o,
    input  logic [REGD_BITS-1:0] reg_read_data_i
);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StSettle,
        StCapt,
        StResp
    } state_e;

    state_e               state_q, state_d;
    logic [REGA_BITS-1:0] addr_q, addr_d;
    logic [REGD_BITS-1:0] wdata_q, wdata_d;
    logic [REGD_BITS-1:0] rsp_data_q, rsp_data_d;
    logic                 rsp_wr_q, rsp_wr_d;
    logic                 accept;

    assign accept = (state_q == StIdle) && req_vld_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_vld_i) begin
                    state_d = req_wr_i ? StWrite : StSettle;
                end
            end
            StWrite:  state_d = StSettle;
            // Bank registers its read data from reg_addr at the end of this cycle.
            StSettle: state_d = StCapt;
            StCapt:   state_d = StResp;
            StResp: begin
                if (rsp_rdy_i) begin
                    state_d = StIdle;
                end
            end
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        req_rdy_o   = rst_ni && (state_q == StIdle);
        rsp_vld_o   = (state_q == StResp);
        reg_write_o = (state_q == StWrite);
    end

    // Address and write data stay put until the next accepted request.
    always_comb begin
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rsp_wr_d   = rsp_wr_q;
        rsp_data_d = rsp_data_q;
        if (accept) begin
            addr_d   = req_addr_i;
            wdata_d  = req_wdata_i;
            rsp_wr_d = req_wr_i;
        end
        if (state_q == StCapt) begin
            rsp_data_d = reg_read_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_wr_q   <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rsp_wr_q   <= rsp_wr_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign reg_addr_o       = addr_q;
    assign reg_write_data_o = wdata_q;
    assign rsp_data_o       = rsp_data_q;
    assign rsp_wr_o         = rsp_wr_q;

endmodule

// File: tb/tb_spio_hss_multiplexer_reg_access.sv
// Directed bench for the register access sequencer, with a small register bank model
// (read-only version word at 0, writable 1..7, all-ones above 7) behind it.
module tb_spio_hss_multiplexer_reg_access;

    localparam logic [31:0] VERSION = 32'h0102_0304;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_vld, req_rdy, req_wr;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_vld, rsp_rdy, rsp_wr;
    logic [31:0] rsp_data;
    logic        reg_write;
    logic [4:0]  reg_addr;
    logic [31:0] reg_write_data, reg_read_data;

    int n_cmp = 0;
    int n_err = 0;
    int wr_pulses = 0;

    always #5 clk = ~clk;

    spio_hss_multiplexer_reg_access #(
        .REGA_BITS(5),
        .REGD_BITS(32)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_vld_i       (req_vld),
        .req_rdy_o       (req_rdy),
        .req_wr_i        (req_wr),
        .req_addr_i      (req_addr),
        .req_wdata_i     (req_wdata),
        .rsp_vld_o       (rsp_vld),
        .rsp_rdy_i       (rsp_rdy),
        .rsp_data_o      (rsp_data),
        .rsp_wr_o        (rsp_wr),
        .reg_write_o     (reg_write),
        .reg_addr_o      (reg_addr),
        .reg_write_data_o(reg_write_data),
        .reg_read_data_i (reg_read_data)
    );

    // Bank model: one-cycle registered read of reg_addr, writes land at the strobe edge.
    logic [31:0] mem [8];
    logic        bank_clr;

    function automatic logic [31:0] bank_val(input logic [4:0] a);
        if (a == 5'd0) return VERSION;
        if (a < 5'd8) return mem[a[2:0]];
        return 32'hFFFF_FFFF;
    endfunction

    always @(posedge clk) begin
        if (bank_clr) begin
            for (int i = 0; i < 8; i++) mem[i] <= '0;
        end else if (reg_write && reg_addr != 5'd0 && reg_addr < 5'd8) begin
            mem[reg_addr[2:0]] <= reg_write_data;
        end
        reg_read_data <= bank_val(reg_addr);
        if (reg_write === 1'b1) wr_pulses <= wr_pulses + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [4:0] a, input logic [31:0] d);
        req_vld   = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
    endtask

    initial begin
        rst_n = 1'b0; bank_clr = 1'b1;
        req_vld = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; rsp_rdy = 1'b0;
        tick(); tick();
        bank_clr = 1'b0;

        // Reset values
        check("rst_req_rdy", 64'(req_rdy), 64'd0);
        check("rst_rsp_vld", 64'(rsp_vld), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_rsp_wr", 64'(rsp_wr), 64'd0);
        check("rst_reg_write", 64'(reg_write), 64'd0);
        check("rst_reg_addr", 64'(reg_addr), 64'd0);
        check("rst_reg_wdata", 64'(reg_write_data), 64'd0);
        rst_n = 1'b1;
        tick();
        check("rel_req_rdy", 64'(req_rdy), 64'd1);

        // Read VERSION: rsp_vld three cycles after the accept cycle
        rsp_rdy = 1'b1;
        issue(1'b0, 5'd0, 32'h0);
        tick();
        req_vld = 1'b0;
        check("rd_settle_rdy", 64'(req_rdy), 64'd0);
        check("rd_settle_vld", 64'(rsp_vld), 64'd0);
        tick();
        check("rd_capt_vld", 64'(rsp_vld), 64'd0);
        tick();
        check("rd_resp_vld", 64'(rsp_vld), 64'd1);
        check("rd_resp_data", 64'(rsp_data), 64'(VERSION));
        check("rd_resp_wr", 64'(rsp_wr), 64'd0);
        tick();
        check("rd_done_vld", 64'(rsp_vld), 64'd0);
        check("rd_done_rdy", 64'(req_rdy), 64'd1);
        check("rd_no_write", 64'(wr_pulses), 64'd0);

        // Write IDSO (addr 1): strobe in the cycle after accept, read-back four cycles on
        issue(1'b1, 5'd1, 32'h0000_A5A5);
        tick();
        req_vld = 1'b0;
        check("wr_strobe", 64'(reg_write), 64'd1);
        check("wr_addr", 64'(reg_addr), 64'd1);
        check("wr_wdata", 64'(reg_write_data), 64'h0000_A5A5);
        tick();
        check("wr_strobe_end", 64'(reg_write), 64'd0);
        tick();
        check("wr_capt_vld", 64'(rsp_vld), 64'd0);
        tick();
        check("wr_resp_vld", 64'(rsp_vld), 64'd1);
        check("wr_resp_data", 64'(rsp_data), 64'h0000_A5A5);
        check("wr_resp_wr", 64'(rsp_wr), 64'd1);
        check("wr_one_pulse", 64'(wr_pulses), 64'd1);
        tick();

        // Write to read-only VERSION under back-pressure; a new request waits meanwhile
        rsp_rdy = 1'b0;
        issue(1'b1, 5'd0, 32'hDEAD_BEEF);
        tick();
        issue(1'b0, 5'd1, 32'h0);
        tick(); tick(); tick();
        check("ro_resp_vld", 64'(rsp_vld), 64'd1);
        check("ro_resp_data", 64'(rsp_data), 64'(VERSION));
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_vld", 64'(rsp_vld), 64'd1);
            check("bp_data", 64'(rsp_data), 64'(VERSION));
            check("bp_wr", 64'(rsp_wr), 64'd1);
            check("bp_req_rdy", 64'(req_rdy), 64'd0);
            check("bp_addr_held", 64'(reg_addr), 64'd0);
        end
        rsp_rdy = 1'b1;
        tick();
        check("bp_done_vld", 64'(rsp_vld), 64'd0);
        check("bp_done_rdy", 64'(req_rdy), 64'd1);

        // Back-to-back reads with req_vld held: IDSO then unmapped
        tick();
        check("b2b_acc1_addr", 64'(reg_addr), 64'd1);
        req_addr = 5'd20;
        tick(); tick();
        check("b2b_rsp1_data", 64'(rsp_data), 64'h0000_A5A5);
        check("b2b_rsp1_rdy", 64'(req_rdy), 64'd0);
        tick();
        check("b2b_idle_rdy", 64'(req_rdy), 64'd1);
        tick();
        check("b2b_acc2_addr", 64'(reg_addr), 64'd20);
        req_vld = 1'b0;
        tick(); tick();
        check("unmapped_vld", 64'(rsp_vld), 64'd1);
        check("unmapped_data", 64'(rsp_data), 64'hFFFF_FFFF);
        check("unmapped_wr", 64'(rsp_wr), 64'd0);
        tick();

        // Reset while in WRITE: strobe drops at once, pending write is lost
        issue(1'b1, 5'd2, 32'h1234_5678);
        tick();
        req_vld = 1'b0;
        check("rw_strobe", 64'(reg_write), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rw_strobe_drop", 64'(reg_write), 64'd0);
        check("rw_rsp_vld", 64'(rsp_vld), 64'd0);
        check("rw_req_rdy", 64'(req_rdy), 64'd0);
        check("rw_addr", 64'(reg_addr), 64'd0);
        check("rw_wdata", 64'(reg_write_data), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rw_rel_rdy", 64'(req_rdy), 64'd1);
        issue(1'b0, 5'd2, 32'h0);
        tick();
        req_vld = 1'b0;
        tick(); tick();
        check("rw_lost_vld", 64'(rsp_vld), 64'd1);
        check("rw_lost_data", 64'(rsp_data), 64'd0);
        tick();
        issue(1'b1, 5'd2, 32'h1234_5678);
        tick();
        req_vld = 1'b0;
        tick(); tick(); tick();
        check("rw_again_vld", 64'(rsp_vld), 64'd1);
        check("rw_again_data", 64'(rsp_data), 64'h1234_5678);
        tick();
        check("rw_again_idle", 64'(req_rdy), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
